gcd_fifo_sched: RTL and testbench



---
 rtl/gcd_fifo_sched.sv | 148 ++++++++++++++
 tb/tb_gcd_fifo_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_fifo_sched.sv
// Sequencer popping operand pairs from a FIFO, computing GCD by repeated subtraction
// and pushing the result. Optional statistics counters under `GCD_STATS_EN.
module gcd_fifo_sched #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    input  logic                  res_full_i,
    output logic                  res_wr_en_o,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic                  busy_o,
    output logic [STAT_WIDTH-1:0] stat_results_o,
    output logic [STAT_WIDTH-1:0] stat_calc_cycles_o
);

    typedef enum logic [2:0] {
        S_FETCH_A = 3'd0,
        S_LATCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_LATCH_B = 3'd3,
        S_CALC    = 3'd4,
        S_WRITE   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] w_a_nxt;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic [DATA_WIDTH-1:0] w_res_nxt;
    logic                  w_rd_en;
    logic                  w_wr_en;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_FETCH_A;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_res   <= w_res_nxt;
            r_busy  <= (w_state_nxt != S_FETCH_A);
        end
    end

    // Next-state, subtract step and FIFO handshakes
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_res_nxt   = r_res;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            S_FETCH_A: begin
                w_rd_en = en_i & ~fifo_empty_i;
                if (w_rd_en) begin
                    w_state_nxt = S_LATCH_A;
                end
            end
            S_LATCH_A: begin
                w_a_nxt     = fifo_data_i;
                w_state_nxt = S_FETCH_B;
            end
            S_FETCH_B: begin
                // A pair, once started, completes regardless of en_i
                w_rd_en = ~fifo_empty_i;
                if (w_rd_en) begin
                    w_state_nxt = S_LATCH_B;
                end
            end
            S_LATCH_B: begin
                w_b_nxt     = fifo_data_i;
                w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (r_b == '0) begin
                    w_res_nxt   = r_a;
                    w_state_nxt = S_WRITE;
                end else if (r_a == '0) begin
                    w_res_nxt   = r_b;
                    w_state_nxt = S_WRITE;
                end else if (r_a == r_b) begin
                    w_res_nxt   = r_a;
                    w_state_nxt = S_WRITE;
                end else if (r_a > r_b) begin
                    w_a_nxt = r_a - r_b;
                end else begin
                    w_b_nxt = r_b - r_a;
                end
            end
            S_WRITE: begin
                w_wr_en = ~res_full_i;
                if (w_wr_en) begin
                    w_state_nxt = S_FETCH_A;
                end
            end
            default: begin
                w_state_nxt = S_FETCH_A;
            end
        endcase
    end

    assign fifo_rd_en_o = w_rd_en;
    assign res_wr_en_o  = w_wr_en;
    assign res_data_o   = r_res;
    assign busy_o       = r_busy;

`ifdef GCD_STATS_EN
    logic [STAT_WIDTH-1:0] r_stat_results;
    logic [STAT_WIDTH-1:0] r_stat_calc;

    // Saturating event counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stat_results <= '0;
            r_stat_calc    <= '0;
        end else begin
            if (w_wr_en && (r_stat_results != '1)) begin
                r_stat_results <= r_stat_results + STAT_WIDTH'(1);
            end
            if ((r_state == S_CALC) && (r_stat_calc != '1)) begin
                r_stat_calc <= r_stat_calc + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_results_o     = r_stat_results;
    assign stat_calc_cycles_o = r_stat_calc;
`else
    assign stat_results_o     = '0;
    assign stat_calc_cycles_o = '0;
`endif

endmodule

// File: tb/tb_gcd_fifo_sched.sv
// Randomized self-checking bench for gcd_fifo_sched against an Euclid-based reference model.
// Build with +define+GCD_STATS_EN to also check the statistics counters.
module tb_gcd_fifo_sched;

    localparam int unsigned DATA_WIDTH = 4;
    localparam int unsigned STAT_WIDTH = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  en_i;
    logic                  fifo_empty_i;
    logic                  fifo_rd_en_o;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  res_full_i;
    logic                  res_wr_en_o;
    logic [DATA_WIDTH-1:0] res_data_o;
    logic                  busy_o;
    logic [STAT_WIDTH-1:0] stat_results_o;
    logic [STAT_WIDTH-1:0] stat_calc_cycles_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Operand FIFO model: pushes from the stimulus, pops on rd_en with registered data
    logic [DATA_WIDTH-1:0] mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_log[$];
    int wr_log[$];
    int wr_dat[$];

    assign fifo_empty_i = (wr_ptr == rd_ptr);

    gcd_fifo_sched #(.DATA_WIDTH(DATA_WIDTH), .STAT_WIDTH(STAT_WIDTH)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_i               (en_i),
        .fifo_empty_i       (fifo_empty_i),
        .fifo_rd_en_o       (fifo_rd_en_o),
        .fifo_data_i        (fifo_data_i),
        .res_full_i         (res_full_i),
        .res_wr_en_o        (res_wr_en_o),
        .res_data_o         (res_data_o),
        .busy_o             (busy_o),
        .stat_results_o     (stat_results_o),
        .stat_calc_cycles_o (stat_calc_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Handshake monitor and FIFO pop
    always @(posedge clk_i) begin
        if (fifo_rd_en_o) begin
            chk("rd_while_empty", 32'(fifo_empty_i), 32'd0);
            rd_log.push_back(cyc);
            fifo_data_i <= mem[rd_ptr[7:0]];
            rd_ptr      <= rd_ptr + 1;
        end
        if (res_wr_en_o) begin
            chk("wr_while_full", 32'(res_full_i), 32'd0);
            wr_log.push_back(cyc);
            wr_dat.push_back(int'(res_data_o));
        end
        cyc <= cyc + 1;
    end

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // CALC length: sum of Euclid quotients (subtractions plus the final equal step)
    function automatic int ref_calc_len(input int a, input int b);
        int n;
        int t;
        if (a == 0 || b == 0) return 1;
        n = 0;
        while (b != 0) begin
            n = n + a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return n;
    endfunction

    task automatic push(input int v);
        mem[wr_ptr % 256] = DATA_WIDTH'(v);
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rd(input int target, input string tag, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (rd_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(tag, 32'd1, 32'd0);
    endtask

    task automatic run_pair(input int a, input int b, input int b_delay,
                            input int full_stall, input bit drop_en);
        int  base_rd;
        int  base_wr;
        int  t0;
        int  t1;
        int  n;
        int  g;
        int  w;
        int  s_res;
        int  s_calc;
        bit  ok;
        base_rd    = rd_log.size();
        base_wr    = wr_log.size();
        s_res      = int'(stat_results_o);
        s_calc     = int'(stat_calc_cycles_o);
        g          = ref_gcd(a, b);
        n          = ref_calc_len(a, b);
        res_full_i = (full_stall > 0);
        en_i       = 1'b1;
        push(a);
        if (b_delay == 0) push(b);
        wait_rd(base_rd + 1, "timeout_rd_a", ok);
        if (!ok) return;
        t0 = rd_log[base_rd];
        if (drop_en) en_i = 1'b0;
        if (b_delay > 0) begin
            repeat (b_delay) @(negedge clk_i);
            chk("fetch_b_stall_rd", 32'(rd_log.size()), 32'(base_rd + 1));
            chk("fetch_b_stall_busy", 32'(busy_o), 32'd1);
            push(b);
        end
        wait_rd(base_rd + 2, "timeout_rd_b", ok);
        if (!ok) return;
        t1 = rd_log[base_rd + 1];
        if (b_delay == 0) chk("rd_b_cycle", 32'(t1), 32'(t0 + 2));
        else              chk("rd_b_after_a", 32'(t1 >= t0 + 2), 32'd1);
        w = t1 + 2 + n;
        if (full_stall > 0) begin
            for (int k = 0; k < 500; k++) begin
                if (cyc >= w + full_stall) begin
                    res_full_i = 1'b0;
                    break;
                end
                if (cyc >= w) begin
                    chk("stall_wr_en", 32'(res_wr_en_o), 32'd0);
                    chk("stall_data_hold", 32'(res_data_o), 32'(g));
                end
                @(negedge clk_i);
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (wr_log.size() > base_wr) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (!ok) begin
            chk("timeout_wr", 32'd1, 32'd0);
            res_full_i = 1'b0;
            en_i       = 1'b1;
            return;
        end
        chk("wr_cycle", 32'(wr_log[base_wr]), 32'(w + full_stall));
        chk("wr_data", 32'(wr_dat[base_wr]), 32'(g));
        chk("rd_count", 32'(rd_log.size()), 32'(base_rd + 2));
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("data_after_wr", 32'(res_data_o), 32'(g));
        @(negedge clk_i);
        chk("single_wr", 32'(wr_log.size()), 32'(base_wr + 1));
`ifdef GCD_STATS_EN
        chk("stat_calc", 32'(int'(stat_calc_cycles_o) - s_calc), 32'(n));
        chk("stat_results", 32'(int'(stat_results_o) - s_res), 32'd1);
`else
        chk("stat_calc_tied", 32'(stat_calc_cycles_o), 32'd0);
        chk("stat_results_tied", 32'(stat_results_o), 32'd0);
`endif
        en_i = 1'b1;
    endtask

    initial begin
        int  base_rd;
        int  base_wr;
        int  t1;
        bit  ok;
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        res_full_i  = 1'b0;
        fifo_data_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_data", 32'(res_data_o), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
        chk("rst_wr_en", 32'(res_wr_en_o), 32'd0);
        chk("rst_stat_calc", 32'(stat_calc_cycles_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_pair(12, 8, 0, 0, 1'b0);
        run_pair(0, 9, 0, 0, 1'b0);
        run_pair(7, 0, 0, 0, 1'b0);
        run_pair(0, 0, 0, 0, 1'b0);
        run_pair(9, 6, 0, 5, 1'b0);
        run_pair(15, 1, 6, 0, 1'b0);

        // Enable low with data waiting, then reset in the middle of CALC
        en_i    = 1'b0;
        base_rd = rd_log.size();
        base_wr = wr_log.size();
        push(15);
        push(1);
        repeat (5) @(negedge clk_i);
        chk("en_low_no_rd", 32'(rd_log.size()), 32'(base_rd));
        chk("en_low_busy", 32'(busy_o), 32'd0);
        en_i = 1'b1;
        wait_rd(base_rd + 2, "timeout_rst_pair", ok);
        if (ok) begin
            t1 = rd_log[base_rd + 1];
            while (cyc < t1 + 7) @(negedge clk_i);
            chk("calc_busy", 32'(busy_o), 32'd1);
            rst_ni = 1'b0;
            @(negedge clk_i);
            chk("midrst_data", 32'(res_data_o), 32'd0);
            chk("midrst_busy", 32'(busy_o), 32'd0);
            chk("midrst_stat", 32'(stat_calc_cycles_o), 32'd0);
            rst_ni = 1'b1;
            repeat (20) @(negedge clk_i);
            chk("midrst_no_wr", 32'(wr_log.size()), 32'(base_wr));
            chk("midrst_idle", 32'(busy_o), 32'd0);
        end
        run_pair(6, 4, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_pair(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
